// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader_if
// Description : Bus between the word source / control unit and the
//               instruction-memory loader.
//               Inputs to the loader : i_start, i_ready_instruc, i_instruc
//               Outputs of the loader: o_mem_we, o_mem_addr, o_mem_data,
//                                      o_busy, o_load_done, o_overflow,
//                                      o_instr_count
//               master = word source / control side, slave = loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_loader_if #(
  parameter int NB_INSTR = 32,
  parameter int NB_ADDR  = 8
);
  logic                i_start;
  logic                i_ready_instruc;
  logic [NB_INSTR-1:0] i_instruc;
  logic                o_mem_we;
  logic [NB_ADDR-1:0]  o_mem_addr;
  logic [NB_INSTR-1:0] o_mem_data;
  logic                o_busy;
  logic                o_load_done;
  logic                o_overflow;
  logic [NB_ADDR:0]    o_instr_count;

  modport master (
    output i_start, i_ready_instruc, i_instruc,
    input  o_mem_we, o_mem_addr, o_mem_data, o_busy, o_load_done,
           o_overflow, o_instr_count
  );

  modport slave (
    input  i_start, i_ready_instruc, i_instruc,
    output o_mem_we, o_mem_addr, o_mem_data, o_busy, o_load_done,
           o_overflow, o_instr_count
  );
endinterface
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader
// Description : Writes assembled instruction words into consecutive
//               instruction-memory addresses starting at 0. A load starts on
//               i_start and ends on the HALT word (DONE) or when memory fills
//               without a HALT (ERROR).
//               Ports: i_clk   - system clock (rising edge)
//                      i_reset - asynchronous active-high reset
//                      bus     - instr_loader_if slave (start / word input,
//                                memory write port and status outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_loader #(
  parameter int                  NB_INSTR  = 32,
  parameter int                  NB_ADDR   = 8,
  parameter logic [NB_INSTR-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  wire logic       i_clk,
  input  wire logic       i_reset,
  instr_loader_if.slave   bus
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_load  = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;
  localparam logic [1:0] c_st_error = 2'd3;

  localparam logic [NB_ADDR:0] c_one = {{NB_ADDR{1'b0}}, 1'b1};

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic                r_ready_prev;
  logic [NB_ADDR:0]    r_count;
  logic                r_mem_we;
  logic [NB_ADDR-1:0]  r_mem_addr;
  logic [NB_INSTR-1:0] r_mem_data;

  logic w_rise;
  logic w_accept;
  logic w_is_halt;
  logic w_at_last;
  logic w_busy;
  logic w_load_done;
  logic w_overflow;

  // The ready flag is a level that may stay high for several cycles, so only
  // its rising edge carries a new word. A coincident start pulse wins and the
  // word on that edge is dropped.
  assign w_rise    = bus.i_ready_instruc & ~r_ready_prev;
  assign w_accept  = (r_state == c_st_load) & w_rise & ~bus.i_start;
  assign w_is_halt = (bus.i_instruc == HALT_WORD);
  // In LOAD the count never reaches full depth, so the low bits all ones
  // means this word lands on the last address.
  assign w_at_last = &r_count[NB_ADDR-1:0];

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle, c_st_done, c_st_error: begin
        if (bus.i_start) begin
          w_next_state = c_st_load;
        end
      end
      c_st_load: begin
        if (bus.i_start) begin
          w_next_state = c_st_load;
        end else if (w_accept) begin
          // HALT on the last address still counts as a clean finish.
          if (w_is_halt) begin
            w_next_state = c_st_done;
          end else if (w_at_last) begin
            w_next_state = c_st_error;
          end
        end
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  // Output logic
  always_comb begin
    w_busy      = 1'b0;
    w_load_done = 1'b0;
    w_overflow  = 1'b0;
    case (r_state)
      c_st_load:  w_busy      = 1'b1;
      c_st_done:  w_load_done = 1'b1;
      c_st_error: w_overflow  = 1'b1;
      default: ;
    endcase
  end

  // Edge detector, word counter and memory write port. Address and data hold
  // their last written values between writes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ready_prev <= 1'b0;
      r_count      <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else begin
      r_ready_prev <= bus.i_ready_instruc;
      r_mem_we     <= w_accept;
      if (bus.i_start) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_count    <= r_count + c_one;
        r_mem_addr <= r_count[NB_ADDR-1:0];
        r_mem_data <= bus.i_instruc;
      end
    end
  end

  assign bus.o_mem_we      = r_mem_we;
  assign bus.o_mem_addr    = r_mem_addr;
  assign bus.o_mem_data    = r_mem_data;
  assign bus.o_busy        = w_busy;
  assign bus.o_load_done   = w_load_done;
  assign bus.o_overflow    = w_overflow;
  assign bus.o_instr_count = r_count;

endmodule
`default_nettype wire

// File: doc/instr_loader.md
# instr_loader

Instruction-memory loader sitting directly downstream of the UART byte-to-word assembler. It consumes each assembled 32-bit instruction and its ready flag, writes the words into consecutive instruction-memory addresses starting at 0, and ends the load when the HALT word arrives or memory fills. It reports completion, word count and overflow to the debug/control unit, which then releases the processor.

## Interface
- NB_INSTR, 32, instruction width
- NB_ADDR, 8, instruction-memory address width (depth 2^NB_ADDR words)
- HALT_WORD, 32'hFFFF_FFFF, word that terminates a program load
- i_clk  input  1  system clock, all logic on rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_start  input  1  one-cycle pulse: begin a new load (clears count, enters LOAD)
- i_ready_instruc  input  1  assembler word-ready flag (level; may stay high several cycles)
- i_instruc  input  NB_INSTR  assembled instruction, valid while i_ready_instruc high
- o_mem_we  output  1  instruction-memory write enable, one-cycle pulse per word
- o_mem_addr  output  NB_ADDR  write address
- o_mem_data  output  NB_INSTR  write data
- o_busy  output  1  high in LOAD
- o_load_done  output  1  high in DONE (HALT received and written)
- o_overflow  output  1  high in ERROR (memory full, no HALT)
- o_instr_count  output  NB_ADDR+1  words written in current load

## Operation
- States: IDLE, LOAD, DONE, ERROR. Reset -> IDLE.
- IDLE: ignore words. i_start -> LOAD, count cleared to 0.
- Word acceptance: only in LOAD, only on rising edge of i_ready_instruc (registered previous value; prev reset value 0). A level held high = exactly one word.
- Accepted word: o_mem_addr = count[NB_ADDR-1:0], o_mem_data = i_instruc, o_mem_we pulse, count += 1.
- Accepted word == HALT_WORD: written like any other word, counted, then LOAD -> DONE.
- Accepted word that makes count == 2^NB_ADDR and is not HALT_WORD: written, LOAD -> ERROR. Word that is HALT at last address -> DONE (not ERROR).
- DONE / ERROR: hold flags and count; ignore further words; i_start -> LOAD with count cleared, flags cleared.
- i_start in LOAD: restart (count 0, stay LOAD); previously written memory is not cleared.
- i_start coincident with a ready rising edge: start wins, that word is dropped.
- o_mem_addr/o_mem_data hold last written values between writes.

## Timing
- Reset values: o_mem_we 0, o_mem_addr 0, o_mem_data 0, o_busy 0, o_load_done 0, o_overflow 0, o_instr_count 0; state IDLE; edge register 0.
- Rising edge of i_ready_instruc sampled at clock edge N -> o_mem_we/addr/data valid for the cycle after edge N (latency 1), o_instr_count updated at edge N.
- HALT accepted at edge N -> o_busy falls and o_load_done rises at edge N (same edge as the write registers).
- i_start sampled at edge N -> o_busy high after edge N; next accepted edge may be edge N+1.
- Back-to-back words require i_ready_instruc low at least one cycle between them; max one write per two cycles.
- Reset asserted mid-load: immediate return to reset values, o_mem_we deasserts asynchronously.

## Test plan
- Reset then i_start, words 0x20010005, 0x20020007, 0xFFFFFFFF each with ready high 3 cycles -> three writes at addr 0,1,2 with those data, o_mem_we 1 cycle each, o_load_done=1, o_instr_count=3.
- Words arriving in IDLE (no i_start) -> no o_mem_we, count stays 0.
- NB_ADDR=2, i_start, four non-HALT words -> writes addr 0..3, o_overflow=1, count=4; fifth word ignored. Repeat with 4th word HALT -> o_load_done=1, o_overflow=0.
- After DONE, extra word 0x11110000 -> no write; then i_start and word 0xAAAA5555 -> written at addr 0, count=1.
- i_start on same cycle as ready rising edge with 0x12345678 -> no write, count 0, o_busy=1.
- Assert i_reset during LOAD after 2 words -> all outputs 0 immediately, state IDLE, next words ignored until i_start.
